// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NUM_RD registered read ports and a
// background clear sweep that zeroes one register per cycle.
// Optional feature: define REGFILE_BYPASS_EN for write-first read bypass; default is read-first.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  state_e                   r_state;
  state_e                   w_state_next;
  logic [ADDR_W-1:0]        r_cnt;
  logic [ADDR_W-1:0]        w_cnt_next;
  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD*DATA_W-1:0] w_rd_next;
  logic [1:0]               w_wr_acc;

  // Accept an external write only when idle and not targeting the hardwired-zero register
  always_comb begin
    w_wr_acc = '0;
    for (int w = 0; w < 2; w++) begin
      w_wr_acc[w] = wr_en[w] && (r_state == StIdle) &&
                    (wr_addr[w*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Sweep FSM next-state and counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (clr_req) begin
          w_state_next = StSweep;
          w_cnt_next   = ADDR_W'(1);
        end
      end
      StSweep: begin
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_next = StDone;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + ADDR_W'(1);
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  // FSM state and sweep counter registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Storage: sweep clear has the array to itself; otherwise port 1 is applied last so it wins
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == StSweep) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (w_wr_acc[w]) begin
          r_mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read data next value; entry 0 is never written so it always reads zero
  always_comb begin
    w_rd_next = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      w_rd_next[k*DATA_W +: DATA_W] = r_mem[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < 2; w++) begin
        if (w_wr_acc[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
          w_rd_next[k*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  // Registered read ports
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign rd_data  = r_rd_data;
  assign clr_busy = (r_state != StIdle);
  assign clr_done = (r_state == StDone);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for single-edge behaviour, hand sequences
// for fill/readback, clear sweep and reset abort.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_addr;
  logic [2*DW-1:0]  wr_data;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .NUM_RD(NR)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[12];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
  endtask

  initial begin
    int          busy_cnt;
    int          done_cnt;
    int          bad_cnt;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] v;

    vecs[0]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0};
    vecs[2]  = '{2'b11, 5'd7, 5'd7, 32'h1111_1111, 32'h2222_2222, 5'd7, 5'd7,
                 Byp ? 32'h2222_2222 : 32'h0, Byp ? 32'h2222_2222 : 32'h0};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 32'h2222_2222, 32'h0};
    vecs[4]  = '{2'b01, 5'd9, 5'd0, 32'h1, 32'h0, 5'd9, 5'd9,
                 Byp ? 32'h1 : 32'h0, Byp ? 32'h1 : 32'h0};
    vecs[5]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h2, 5'd9, 5'd9,
                 Byp ? 32'h2 : 32'h1, Byp ? 32'h2 : 32'h1};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd7, 32'h2, 32'h2222_2222};
    vecs[7]  = '{2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 5'd3, 5'd4,
                 Byp ? 32'h33 : 32'h0, Byp ? 32'h44 : 32'h0};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd3, 32'h44, 32'h33};
    vecs[9]  = '{2'b10, 5'd0, 5'd0, 32'h0, 32'hDEAD, 5'd0, 5'd0, 32'h0, 32'h0};
    vecs[10] = '{2'b11, 5'd12, 5'd0, 32'hAAA, 32'hBBB, 5'd12, 5'd0,
                 Byp ? 32'hAAA : 32'h0, 32'h0};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd12, 32'hAAA, 32'hAAA};

    clr_req = 1'b0;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

    // Reset state
    #12;
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_rd1", rd_data[63:32], 32'h0);
    chk("reset_busy", {31'h0, clr_busy}, 32'h0);
    chk("reset_done", {31'h0, clr_done}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;

    // Single-edge vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
            vecs[i].ra0, vecs[i].ra1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_p0", i), rd_data[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_p1", i), rd_data[63:32], vecs[i].e1);
    end

    // Fill 1..31, alternating write ports; idle port carries junk data
    for (int n = 1; n < 32; n++) begin
      @(negedge clk);
      a = 5'(n);
      v = 32'hA5A5_0000 + 32'(n);
      if (n % 2 == 1) drive(2'b10, a, a, 32'hBAD0_0000, v, 5'd0, 5'd0);
      else            drive(2'b01, a, a, v, 32'hBAD0_0000, 5'd0, 5'd0);
    end
    @(negedge clk);
    wr_en = 2'b00;

    // Readback with the two ports walking in opposite directions
    for (int n = 1; n < 32; n++) begin
      @(negedge clk);
      a = 5'(n);
      b = 5'(32 - n);
      rd_addr = {b, a};
      @(posedge clk);
      #1;
      chk($sformatf("fill_rd%0d_p0", n), rd_data[31:0], 32'hA5A5_0000 + 32'(n));
      chk($sformatf("fill_rd%0d_p1", n), rd_data[63:32], 32'hA5A5_0000 + 32'(32 - n));
    end

    // Clear sweep; the write on the start edge lands, later writes and requests are ignored
    @(negedge clk);
    clr_req = 1'b1;
    drive(2'b01, 5'd20, 5'd0, 32'hCAFE_0020, 32'h0, 5'd20, 5'd31);
    @(posedge clk);
    #1;
    busy_cnt = clr_busy ? 1 : 0;
    done_cnt = clr_done ? 1 : 0;
    chk("sweep_start_busy", {31'h0, clr_busy}, 32'h1);
    @(negedge clk);
    drive(2'b01, 5'd1, 5'd0, 32'hBAD0_0001, 32'h0, 5'd20, 5'd31);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk("sweep_rd_new20", rd_data[31:0], 32'hCAFE_0020);
        chk("sweep_rd_old31", rd_data[63:32], 32'hA5A5_001F);
      end
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (!clr_busy) break;
    end
    chk("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
    @(negedge clk);
    clr_req = 1'b0;
    wr_en   = 2'b00;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      a = 5'(n);
      b = 5'(31 - n);
      rd_addr = {b, a};
      @(posedge clk);
      #1;
      chk($sformatf("clr_rd%0d_p0", n), rd_data[31:0], 32'h0);
      chk($sformatf("clr_rd%0d_p1", n), rd_data[63:32], 32'h0);
    end

    // Reset abort at sweep counter 10
    @(negedge clk);
    drive(2'b01, 5'd25, 5'd0, 32'h25, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    clr_req = 1'b1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd25, 5'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("abort_pre_busy", {31'h0, clr_busy}, 32'h1);
    chk("abort_pre_rd0", rd_data[31:0], 32'h25);
    nrst = 1'b0;
    #1;
    chk("abort_rd0", rd_data[31:0], 32'h0);
    chk("abort_rd1", rd_data[63:32], 32'h0);
    chk("abort_busy", {31'h0, clr_busy}, 32'h0);
    chk("abort_done", {31'h0, clr_done}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    bad_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (clr_busy || clr_done) bad_cnt++;
    end
    chk("abort_no_done", 32'(bad_cnt), 32'd0);
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd25, 5'd25);
    @(posedge clk);
    #1;
    chk("abort_mem_cleared", rd_data[31:0], 32'h0);
    @(negedge clk);
    drive(2'b10, 5'd0, 5'd25, 32'h0, 32'h77, 5'd25, 5'd0);
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd25, 5'd0);
    @(posedge clk);
    #1;
    chk("post_abort_write", rd_data[31:0], 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (clk, nrst).
REQ-002 Parameter DATA_W SHALL default to 32 and set the register width in bits.
REQ-003 Parameter ADDR_W SHALL default to 5 and set DEPTH = 2**ADDR_W registers.
REQ-004 Parameter NUM_RD SHALL default to 2, legal range 1..4, and set the number of read ports.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 nrst  input  1  asynchronous active-low reset.
REQ-007 rd_addr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  NUM_RD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-009 wr_en  input  2  per-write-port enables.
REQ-010 wr_addr  input  2*ADDR_W  write addresses; port w occupies bits [w*ADDR_W +: ADDR_W].
REQ-011 wr_data  input  2*DATA_W  write data; port w occupies bits [w*DATA_W +: DATA_W].
REQ-012 clr_req  input  1  single-cycle request to clear all registers.
REQ-013 clr_busy  output  1  high while a clear sweep is in progress.
REQ-014 clr_done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-015 Register 0 SHALL always read as 0; writes to address 0 SHALL be discarded.
REQ-016 A write SHALL take effect at the rising edge of clk on which wr_en[w]=1.
REQ-017 If both write ports target the same nonzero address in the same cycle, port 1 SHALL win and port 0 SHALL be dropped.
REQ-018 Reads SHALL have one-cycle latency: rd_data for port k SHALL equal the contents at rd_addr sampled at edge N, presented after edge N.
REQ-019 All read ports SHALL be independent; any ports may read the same address.
REQ-020 The sweep FSM SHALL have states IDLE, SWEEP, DONE; it SHALL reset to IDLE.
REQ-021 IDLE -> SWEEP SHALL occur on an edge with clr_req=1; the sweep counter SHALL load 1.
REQ-022 In SWEEP, one register per cycle SHALL be cleared at the counter address, and the counter SHALL increment; at counter = DEPTH-1 the register SHALL be cleared and the FSM SHALL go to DONE (DEPTH-1 SWEEP cycles).
REQ-023 DONE SHALL last one cycle with clr_done=1, then return to IDLE.
REQ-024 clr_busy SHALL be 1 in SWEEP and DONE, and 0 in IDLE.
REQ-025 While clr_busy=1, all external writes SHALL be dropped and clr_req SHALL be ignored.
REQ-026 Reads during a sweep SHALL return current contents, partially cleared, with no stall.
REQ-027 clr_req and wr_en asserted on the same edge in IDLE SHALL start the sweep and also perform the write; the sweep later clears that register.

Reset
REQ-028 When nrst=0, all registers, rd_data, the sweep counter, clr_busy and clr_done SHALL go to 0 immediately, and the FSM SHALL go to IDLE.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep; no clr_done pulse SHALL be produced.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, a read of address A on the same edge as an accepted write to A SHALL return the new write data (write-first, port-1 priority applied).
REQ-031 Without REGFILE_BYPASS_EN, that read SHALL return the old contents (read-first); the new data SHALL be visible from the following read.
REQ-032 Address 0 SHALL read 0 in both configurations.

Verification
REQ-033 Write 32'hFFFFFFFF to addr 0, then read addr 0 on all ports -> rd_data = 0.
REQ-034 Write addr n with 32'hA5A50000+n for n=1..31, then read each addr on every port -> exact match, 1-cycle latency.
REQ-035 wr_en=2'b11, both ports addr 7, data 32'h11111111 / 32'h22222222 -> addr 7 reads 32'h22222222.
REQ-036 Addr 9 holds 32'h1; on the same edge write 32'h2 to addr 9 and read addr 9 -> 32'h2 with REGFILE_BYPASS_EN, 32'h1 without.
REQ-037 Fill all registers, pulse clr_req -> clr_busy high for 32 cycles (31 SWEEP + 1 DONE), clr_done pulses once, writes during the sweep are dropped, all addresses then read 0.
REQ-038 Assert nrst=0 during SWEEP at counter 10 -> all outputs 0 immediately, FSM in IDLE, no clr_done pulse.
